mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Bus initiator inside `cpu` that owns the byte-wide system memory port (`mem_a`/`mem_dout`/`mem_wr` out, `mem_din` in). Arbitrates instruction-fetch word reads and load/store-unit (LSU) accesses of 1/2/4 bytes, serialising each into single-byte bus cycles against a synchronous responder that returns read data one cycle after the address. Handles the debug pause (`rdy_in`) and UART back-pressure (`io_buffer_full`) for I/O writes.

## Interface
- ADDR_WIDTH, 32: CPU address width.
- IO_HI, 2'b11: value of `mem_a[17:16]` that selects I/O space.
- clk_in  in  1  system clock, all logic on rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  bus grant; 0 = paused, bus owned by the debug block.
- mem_din  in  8  read byte; valid the cycle after its address was driven.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write cycle.
- io_buffer_full  in  1  UART TX buffer full.
- if_req_in  in  1  fetch request, held until `if_done_out`.
- if_addr_in  in  32  fetch address (word-aligned).
- if_done_out  out  1  one-cycle pulse; `if_data_out` valid.
- if_data_out  out  32  fetched word, little-endian.
- ls_req_in  in  1  LSU request, held until `ls_done_out`.
- ls_wr_in  in  1  1 = store.
- ls_size_in  in  2  0 byte, 1 half, 2 word; 3 illegal (treated as 2).
- ls_addr_in  in  32  access address.
- ls_wdata_in  in  32  store data, low bytes used.
- ls_done_out  out  1  one-cycle pulse.
- ls_rdata_out  out  32  load data, zero-extended.
- flush_in  in  1  abort pending/in-flight fetch.

## Operation
- States: IDLE, READ, WRITE. Byte counters: `issue` (next byte to drive), `cap` (next byte to capture), `len` = 1/2/4.
- IDLE: `ls_req_in` has priority over `if_req_in`; the granted request is latched (address, size, data) and the first byte is issued in the same cycle. No preemption mid-transfer.
- READ: drives `mem_a = base+issue`, `mem_wr=0`, while issue<len. Captures `mem_din` into byte `cap` each cycle following an issue. When cap reaches len: pulse the matching done, load the result output, return to IDLE.
- WRITE: drives `mem_a = base+issue`, `mem_dout = wdata[8*issue+7 -: 8]`, `mem_wr=1`. Done pulses in the cycle after the last byte is written.
- I/O write (addr[17:16]==IO_HI): a byte is issued only if `io_buffer_full`=0 in that cycle and the previous cycle was not a write; otherwise `mem_wr=0` and the byte is stalled.
- I/O read: single byte; never started for a fetch.
- `rdy_in`=0: all state frozen, `mem_wr` forced 0. The first `rdy_in`=1 cycle after a pause discards `mem_din` and sets issue := cap, re-issuing the lost byte.
- `flush_in`: in IDLE or READ of a fetch, returns to IDLE immediately with no `if_done_out`. Never aborts an LSU access. A flush coinciding with fetch completion suppresses the done.
- Address arithmetic: base+issue is 32-bit with wrap-around; no alignment check.

## Timing
- Reset: `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `if_done_out`=0, `ls_done_out`=0, `if_data_out`=0, `ls_rdata_out`=0, state IDLE.
- N-byte read granted at cycle 0: addresses driven in cycles 0..N-1; done pulses in cycle N+1 (word fetch: 6 cycles request-to-done).
- N-byte non-I/O write granted at cycle 0: bytes in cycles 0..N-1; done in cycle N.
- Back-to-back: a new grant may occur in the cycle after done; the requester must deassert req in the done cycle or it is re-served.
- Result outputs hold their value until the next done.

## Test plan
- Word fetch at 0x0000_0004, memory bytes 0x13,0x05,0x10,0x00 -> `if_done_out` pulses 6 cycles after request, `if_data_out`=0x0010_0513.
- Simultaneous `if_req_in` and `ls_req_in` (sw 0xDEADBEEF to 0x100) -> write served first: `mem_wr`=1 at 0x100..0x103 with EF,BE,AD,DE; fetch follows.
- Byte store to 0x30000 with `io_buffer_full`=1 for 5 cycles -> `mem_wr` stays 0 for those cycles, then one write of the byte, `ls_done_out` the next cycle.
- `rdy_in`=0 for 3 cycles mid-way through a word load of 0x12345678 -> after resume the interrupted byte is re-read; `ls_rdata_out`=0x12345678.
- `flush_in` pulsed 2 cycles into a fetch -> no `if_done_out`; the next queued request starts in the following cycle.
- Reset asserted mid-write -> all outputs 0 asynchronously; after release, `mem_wr`=0 until a new request.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serialising memory bus initiator shared by instruction fetch and the LSU.
// Bus outputs are combinational from state so a granted request drives its first byte in the grant cycle.
module mem_ctrl #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_HI      = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_wr_in,
  input  logic [1:0]            ls_size_in,
  input  logic [ADDR_WIDTH-1:0] ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  input  logic                  flush_in
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t                st_q, st_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, b_w, a_w;
  logic [31:0]           wdata_q, wdata_d, wd_w, acc_q, acc_d, acc_new;
  logic [31:0]           if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
  logic [2:0]            len_q, len_d, issue_q, issue_d, cap_q, cap_d, ei, len_w, ls_len;
  logic                  fetch_q, fetch_d, dvld_q, dvld_d, paused_q, wrp_q;
  logic                  if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic                  go, ls_grant, if_grant, grant, abort, wr_w, drive, do_wr, do_rd, cap_hit;
  assign go       = rst_n_in & rdy_in;
  // No grant in a done cycle, so a requester dropping req on done is never re-served.
  assign ls_grant = go & (st_q == IDLE) & ls_req_in & ~if_done_q & ~ls_done_q;
  assign if_grant = go & (st_q == IDLE) & ~ls_req_in & if_req_in & ~flush_in &
                    (if_addr_in[17:16] != IO_HI) & ~if_done_q & ~ls_done_q;
  assign grant    = ls_grant | if_grant;
  assign abort    = go & (st_q == READ) & fetch_q & flush_in;
  assign ls_len   = (ls_size_in == 2'd0 || (!ls_wr_in && ls_addr_in[17:16] == IO_HI)) ? 3'd1 :
                    (ls_size_in == 2'd1) ? 3'd2 : 3'd4;
  assign b_w      = ls_grant ? ls_addr_in : if_grant ? if_addr_in : base_q;
  assign wd_w     = ls_grant ? ls_wdata_in : wdata_q;
  assign len_w    = ls_grant ? ls_len : if_grant ? 3'd4 : len_q;
  assign wr_w     = ls_grant ? ls_wr_in : (st_q == WRITE);
  // After a pause, restart from the first byte not yet confirmed.
  assign ei       = (st_q == IDLE) ? 3'd0 : paused_q ? cap_q : issue_q;
  assign a_w      = b_w + ADDR_WIDTH'(ei);
  assign drive    = (grant | (go & (st_q != IDLE) & ~abort)) & (ei < len_w);
  assign do_wr    = drive & wr_w & ((a_w[17:16] != IO_HI) | (~io_buffer_full & ~wrp_q));
  assign do_rd    = drive & ~wr_w;
  assign cap_hit  = go & (st_q == READ) & ~abort & ~paused_q & dvld_q;
  assign acc_new  = acc_q | (32'(mem_din) << {cap_q[1:0], 3'b000});
  assign mem_a    = drive ? a_w : '0;
  assign mem_wr   = do_wr;
  assign mem_dout = (drive & wr_w) ? 8'(wd_w >> {ei[1:0], 3'b000}) : 8'h00;
  assign if_done_out  = if_done_q;
  assign if_data_out  = if_data_q;
  assign ls_done_out  = ls_done_q;
  assign ls_rdata_out = ls_rdata_q;
  always_comb begin
    st_d       = st_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    issue_d    = issue_q;
    cap_d      = cap_q;
    fetch_d    = fetch_q;
    acc_d      = acc_q;
    dvld_d     = dvld_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if (go) begin
      dvld_d  = do_rd;
      issue_d = ei + 3'(do_rd | do_wr);
      if (grant) begin
        st_d    = wr_w ? WRITE : READ;
        base_d  = b_w;
        wdata_d = wd_w;
        len_d   = len_w;
        fetch_d = if_grant;
        acc_d   = '0;
        cap_d   = '0;
      end
      if (wr_w) cap_d = issue_d;
      if (abort) st_d = IDLE;
      if (cap_hit) begin
        acc_d = acc_new;
        cap_d = cap_q + 3'd1;
        if (cap_q + 3'd1 == len_q) begin
          st_d       = IDLE;
          if_done_d  = fetch_q;
          ls_done_d  = ~fetch_q;
          if_data_d  = fetch_q ? acc_new : if_data_q;
          ls_rdata_d = fetch_q ? ls_rdata_q : acc_new;
        end
      end
      if (do_wr && ei + 3'd1 == len_w) begin
        st_d      = IDLE;
        ls_done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st_q       <= IDLE;
      base_q     <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
      issue_q    <= '0;
      cap_q      <= '0;
      fetch_q    <= 1'b0;
      acc_q      <= '0;
      dvld_q     <= 1'b0;
      paused_q   <= 1'b0;
      wrp_q      <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      st_q       <= st_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      cap_q      <= cap_d;
      fetch_q    <= fetch_d;
      acc_q      <= acc_d;
      dvld_q     <= dvld_d;
      paused_q   <= ~rdy_in;
      wrp_q      <= do_wr;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a synchronous byte responder.
module tb_mem_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, io_full = 1'b0;
  logic [7:0]  mem_din = 8'h00, mem_dout;
  logic [31:0] mem_a, if_addr = '0, if_data, ls_addr = '0, ls_wdata = '0, ls_rdata;
  logic        mem_wr, if_req = 1'b0, if_done, ls_req = 1'b0, ls_wr = 1'b0, ls_done, flush = 1'b0;
  logic [1:0]  ls_size = 2'd0;
  int          total = 0, bad = 0, if_pulses = 0;

  mem_ctrl dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_full), .if_req_in(if_req),
    .if_addr_in(if_addr), .if_done_out(if_done), .if_data_out(if_data), .ls_req_in(ls_req),
    .ls_wr_in(ls_wr), .ls_size_in(ls_size), .ls_addr_in(ls_addr), .ls_wdata_in(ls_wdata),
    .ls_done_out(ls_done), .ls_rdata_out(ls_rdata), .flush_in(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h4:   return 8'h13;
      32'h5:   return 8'h05;
      32'h6:   return 8'h10;
      32'h7:   return 8'h00;
      32'h8:   return 8'h11;
      32'h9:   return 8'h22;
      32'hA:   return 8'h33;
      32'hB:   return 8'h44;
      32'h200: return 8'h78;
      32'h201: return 8'h56;
      32'h202: return 8'h34;
      32'h203: return 8'h12;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk) mem_din <= rom(mem_a);
  always @(negedge clk) if (if_done) if_pulses <= if_pulses + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the current one until the selected done pulse; ends at that cycle's negedge.
  task automatic await(input string tag, input bit f, input int exp);
    int n = -1;
    for (int i = 0; i < 40 && n < 0; i++) begin
      @(negedge clk);
      if (f ? if_done : ls_done) n = i;
      else nxt();
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    logic [31:0] w;
    int snap;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 0);
    chk("rst_if_done", {31'b0, if_done}, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    rst_n = 1'b1;
    nxt();
    // word fetch: addresses in cycles 0..3, done in cycle 5
    if_req = 1'b1; if_addr = 32'h4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) chk("f1_addr", mem_a, 32'(4 + k));
      chk("f1_done", {31'b0, if_done}, {31'b0, k == 5});
      if (k < 5) nxt();
    end
    chk("f1_data", if_data, 32'h0010_0513);
    if_req = 1'b0;
    nxt();
    @(negedge clk);
    chk("f1_hold", if_data, 32'h0010_0513);
    nxt();
    // simultaneous requests: store wins, fetch follows
    w = 32'hDEAD_BEEF;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h100; ls_wdata = w;
    if_req = 1'b1; if_addr = 32'h8;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("sw_wr", {31'b0, mem_wr}, 1);
      chk("sw_addr", mem_a, 32'(32'h100 + k));
      chk("sw_byte", {24'b0, mem_dout}, {24'b0, w[8*k +: 8]});
      nxt();
    end
    @(negedge clk);
    chk("sw_done", {31'b0, ls_done}, 1);
    chk("sw_wr_off", {31'b0, mem_wr}, 0);
    ls_req = 1'b0;
    nxt();
    await("sw_fetch_cyc", 1'b1, 5);
    chk("sw_fetch_data", if_data, 32'h4433_2211);
    if_req = 1'b0;
    nxt();
    // I/O byte store held off by a full UART buffer
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h3_0000; ls_wdata = 32'h5A; io_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("io_stall", {31'b0, mem_wr}, 0);
      nxt();
    end
    io_full = 1'b0;
    @(negedge clk);
    chk("io_wr", {31'b0, mem_wr}, 1);
    chk("io_addr", mem_a, 32'h3_0000);
    chk("io_byte", {24'b0, mem_dout}, 32'h5A);
    chk("io_early_done", {31'b0, ls_done}, 0);
    nxt();
    @(negedge clk);
    chk("io_done", {31'b0, ls_done}, 1);
    ls_req = 1'b0;
    nxt();
    // word load paused for 3 cycles after two bytes were addressed
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
    @(negedge clk);
    chk("ld_a0", mem_a, 32'h200);
    nxt();
    @(negedge clk);
    chk("ld_a1", mem_a, 32'h201);
    nxt();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ld_pause_done", {31'b0, ls_done}, 0);
      nxt();
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("ld_reissue", mem_a, 32'h201);
    nxt();
    await("ld_cyc", 1'b0, 3);
    chk("ld_data", ls_rdata, 32'h1234_5678);
    ls_req = 1'b0;
    nxt();
    // word store paused for one cycle: write forced off, then byte 1 rewritten
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'hA1B2_C3D4;
    @(negedge clk);
    chk("wp_a0", mem_a, 32'h400);
    nxt();
    rdy = 1'b0;
    @(negedge clk);
    chk("wp_forced_off", {31'b0, mem_wr}, 0);
    nxt();
    rdy = 1'b1;
    @(negedge clk);
    chk("wp_resume_a", mem_a, 32'h401);
    chk("wp_resume_b", {24'b0, mem_dout}, 32'hC3);
    chk("wp_resume_wr", {31'b0, mem_wr}, 1);
    nxt();
    await("wp_cyc", 1'b0, 2);
    ls_req = 1'b0;
    nxt();
    // flush two cycles into a fetch, with a byte load queued behind it
    snap = if_pulses;
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("fl_a0", mem_a, 32'h40);
    nxt();
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h200;
    @(negedge clk);
    chk("fl_no_preempt", mem_a, 32'h41);
    nxt();
    flush = 1'b1; if_req = 1'b0;
    nxt();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_next_a", mem_a, 32'h200);
    nxt();
    await("fl_ld_cyc", 1'b0, 1);
    chk("fl_ld_data", ls_rdata, 32'h78);
    ls_req = 1'b0;
    repeat (6) nxt();
    chk("fl_no_if_done", 32'(if_pulses), 32'(snap));
    // asynchronous reset in the middle of a store
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'h0102_0304;
    @(negedge clk);
    chk("rs_wr_before", {31'b0, mem_wr}, 1);
    nxt();
    #1 rst_n = 1'b0;
    #1;
    chk("rs_mem_wr", {31'b0, mem_wr}, 0);
    chk("rs_mem_a", mem_a, 0);
    chk("rs_mem_dout", {24'b0, mem_dout}, 0);
    chk("rs_if_data", if_data, 0);
    chk("rs_ls_rdata", ls_rdata, 0);
    chk("rs_ls_done", {31'b0, ls_done}, 0);
    ls_req = 1'b0;
    nxt();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rs_quiet", {31'b0, mem_wr}, 0);
      nxt();
    end
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h10; ls_wdata = 32'h77;
    @(negedge clk);
    chk("rs_new_wr", {31'b0, mem_wr}, 1);
    chk("rs_new_a", mem_a, 32'h10);
    nxt();
    @(negedge clk);
    chk("rs_new_done", {31'b0, ls_done}, 1);
    ls_req = 1'b0;
    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
